leg_gate_monitor: RTL and testbench
===================================

# leg_gate_monitor

Observer for one inverter leg's complementary gate pair (Q1 top, Q2 bottom), as produced by the leg switching logic or returned from gate-driver feedback. It decodes the pair back into the commanded leg state and measures every dead-time interval in clock cycles. It flags shoot-through, short dead time and stalled (over-long) dead time as sticky faults for the protection and telemetry logic. It sits beside each leg's switch block, clocked by the same 50 MHz CLK.

## Interface
- CNT_W, 8: dead-time counter and DT_LAST width; the counter saturates at 2^CNT_W-1.
- MIN_DEADTIME, 5: minimum legal both-off cycles on a polarity change (5 cycles = 100 ns).
- MAX_DEADTIME, 64: both-off cycle count after a side at which FAULT_DT_LONG sets.

- CLK  in  1  system clock, 50 MHz, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- Q1  in  1  top-switch gate signal.
- Q2  in  1  bottom-switch gate signal.
- FAULT_CLR  in  1  single-cycle request to clear the sticky fault flags.
- LEG_STATE  out  1  decoded leg output: 1 = high, 0 = low.
- LEG_VALID  out  1  1 while exactly one switch is on (states HIGH or LOW).
- DT_LAST  out  CNT_W  length of the most recently completed dead time, in cycles.
- DT_VALID  out  1  one-cycle pulse when DT_LAST updates.
- FAULT_SHOOT  out  1  sticky: Q1 and Q2 seen on together.
- FAULT_DT_SHORT  out  1  sticky: a polarity change had dead time below MIN_DEADTIME.
- FAULT_DT_LONG  out  1  sticky: dead time reached MAX_DEADTIME.
- FAULT  out  1  OR of the three sticky flags.

## Operation
- Q1 and Q2 are registered once into q_r at each rising edge. All decisions use q_r.
- The FSM has five states:
  - IDLE: entered at reset; no side known yet.
  - HIGH: q_r = 10.
  - LOW: q_r = 01.
  - DEAD: q_r = 00 after a side.
  - SHOOT: q_r = 11 seen.
- Transition rules:
  - From any state, q_r = 11 goes to SHOOT and sets FAULT_SHOOT.
  - IDLE goes to HIGH on 10 and to LOW on 01. Time spent in IDLE is never measured.
  - HIGH or LOW goes to DEAD on 00. The counter loads 1 and prev_side records the side just left.
  - In DEAD, the counter increments each cycle and saturates.
    - If the counter equals MAX_DEADTIME, FAULT_DT_LONG sets.
    - On 10 or 01, the FSM moves to that side, DT_LAST takes the counter value and DT_VALID pulses.
    - If the new side differs from prev_side and the count is below MIN_DEADTIME, FAULT_DT_SHORT sets.
    - A return to the same side is measured but never flagged short.
  - A direct HIGH to LOW or LOW to HIGH change (no 00 sample) records DT_LAST = 0, pulses DT_VALID and sets FAULT_DT_SHORT when MIN_DEADTIME > 0.
  - SHOOT goes to DEAD on 00, with prev_side = none, so no short check applies on exit. SHOOT goes directly to HIGH or LOW on 10 or 01, with no measurement.
- LEG_STATE outputs:
  - 1 in HIGH, 0 in LOW.
  - Holds its last value in DEAD and SHOOT.
  - 0 in IDLE.
- Sticky flags clear on FAULT_CLR. A fault that sets in the same cycle wins over the clear. FAULT_CLR has no effect on the FSM, the counter or DT_LAST.

## Timing
- Reset (asynchronous, RST_N low) forces:
  - state IDLE;
  - q_r = 00;
  - counter, DT_LAST and prev_side cleared;
  - every output 0.
  - A reset during DEAD or SHOOT discards the interval in progress, and no DT_VALID pulse follows.
- Latency: a pin change sampled at edge n is reflected in state and outputs after edge n+1 (2 cycles).
- DT_LAST equals the number of consecutive edges at which 00 was sampled. For example, 5 samples give DT_LAST = 5.
- The counter stops at 2^CNT_W-1. FAULT_DT_LONG sets exactly once per interval, at the edge where the counter equals MAX_DEADTIME.
- DT_VALID and the matching fault flag assert on the same edge as the state change out of DEAD.

## Test plan
- Reset check: assert RST_N=0 mid-run with Q1=1 -> all outputs 0 immediately. After release with 00 held, the FSM stays in IDLE, LEG_VALID=0 and there is no DT_VALID.
- Nominal transition: hold Q1Q2=10 for 10 cycles, then 00 for 5, then 01 -> LEG_STATE goes 1 then 0, DT_LAST=5 with one DT_VALID pulse, FAULT=0.
- Short dead time: hold 01, then 00 for 3 cycles, then 10 -> DT_LAST=3, FAULT_DT_SHORT=1 and FAULT=1, held until FAULT_CLR. After a 1-cycle FAULT_CLR, both read 0.
- Shoot-through: drive 11 for 1 cycle between 10 and 00 -> FAULT_SHOOT=1 two edges later and LEG_VALID=0 while in SHOOT. The following 00 for 2 cycles then 01 sets no short fault.
- Stalled dead time: hold 10, then 00 for 70 cycles, then 01 -> FAULT_DT_LONG sets on the 64th counted cycle, then DT_LAST=70 with DT_VALID.
- Clear collision: assert FAULT_CLR on the edge that detects 11 -> FAULT_SHOOT stays 1. Separately, a direct 10->01 change gives DT_LAST=0 and FAULT_DT_SHORT=1.

Source files
------------

// File: rtl/leg_gate_monitor.sv
// leg_gate_monitor
// Observes one inverter leg's complementary gate pair (Q1 top, Q2 bottom),
// decodes the commanded leg state, measures every dead-time interval in CLK
// cycles and raises sticky shoot-through / short / stalled dead-time faults.
module leg_gate_monitor #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned MIN_DEADTIME = 5,
    parameter int unsigned MAX_DEADTIME = 64
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Q1,
    input  logic             Q2,
    input  logic             FAULT_CLR,
    output logic             LEG_STATE,
    output logic             LEG_VALID,
    output logic [CNT_W-1:0] DT_LAST,
    output logic             DT_VALID,
    output logic             FAULT_SHOOT,
    output logic             FAULT_DT_SHORT,
    output logic             FAULT_DT_LONG,
    output logic             FAULT
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_DEAD,
        ST_SHOOT
    } state_t;

    typedef enum logic [1:0] {
        SIDE_NONE,
        SIDE_HIGH,
        SIDE_LOW
    } side_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       q_r;
    state_t           state;
    side_t            prev_side;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    logic q_hi;
    logic q_lo;
    logic q_off;
    logic q_both;

    logic from_side;
    logic enter_dead;
    logic stay_dead;
    logic exit_dead;
    logic direct_flip;
    logic side_change;

    logic set_shoot;
    logic set_short;
    logic set_long;

    logic shoot_nxt;
    logic short_nxt;
    logic long_nxt;

    // Register the raw gate pair once; every decision below uses q_r.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_r <= '0;
        end else begin
            q_r <= {Q1, Q2};
        end
    end

    assign q_hi   = (q_r == 2'b10);
    assign q_lo   = (q_r == 2'b01);
    assign q_off  = (q_r == 2'b00);
    assign q_both = (q_r == 2'b11);

    // Saturating increment of the dead-time counter.
    always_comb begin
        cnt_inc = cnt;
        if (cnt != '1) begin
            cnt_inc = cnt + 1'b1;
        end
    end

    assign from_side   = (state == ST_HIGH) || (state == ST_LOW);
    assign enter_dead  = q_off && (from_side || (state == ST_SHOOT));
    assign stay_dead   = q_off && (state == ST_DEAD);
    assign exit_dead   = (q_hi || q_lo) && (state == ST_DEAD);
    assign direct_flip = ((state == ST_HIGH) && q_lo) || ((state == ST_LOW) && q_hi);
    assign side_change = exit_dead &&
                         ((q_hi && (prev_side == SIDE_LOW)) ||
                          (q_lo && (prev_side == SIDE_HIGH)));

    // Fault set conditions. The long-fault test only fires on a real
    // increment, so a saturated counter cannot re-raise it after a clear.
    assign set_shoot = q_both;
    assign set_short = (side_change && (32'(cnt) < MIN_DEADTIME)) ||
                       (direct_flip && (MIN_DEADTIME != 0));
    assign set_long  = (enter_dead && (MAX_DEADTIME == 1)) ||
                       (stay_dead && (cnt_inc != cnt) &&
                        (32'(cnt_inc) == MAX_DEADTIME));

    // A fault raised in the same cycle as FAULT_CLR wins over the clear.
    assign shoot_nxt = set_shoot | (FAULT_SHOOT    & ~FAULT_CLR);
    assign short_nxt = set_short | (FAULT_DT_SHORT & ~FAULT_CLR);
    assign long_nxt  = set_long  | (FAULT_DT_LONG  & ~FAULT_CLR);

    // Leg FSM with dead-time measurement and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state          <= ST_IDLE;
            prev_side      <= SIDE_NONE;
            cnt            <= '0;
            DT_LAST        <= '0;
            DT_VALID       <= 1'b0;
            LEG_STATE      <= 1'b0;
            LEG_VALID      <= 1'b0;
            FAULT_SHOOT    <= 1'b0;
            FAULT_DT_SHORT <= 1'b0;
            FAULT_DT_LONG  <= 1'b0;
            FAULT          <= 1'b0;
        end else begin
            DT_VALID       <= 1'b0;
            FAULT_SHOOT    <= shoot_nxt;
            FAULT_DT_SHORT <= short_nxt;
            FAULT_DT_LONG  <= long_nxt;
            FAULT          <= shoot_nxt | short_nxt | long_nxt;

            if (q_both) begin
                state     <= ST_SHOOT;
                LEG_VALID <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (q_hi) begin
                            state     <= ST_HIGH;
                            LEG_STATE <= 1'b1;
                            LEG_VALID <= 1'b1;
                        end else if (q_lo) begin
                            state     <= ST_LOW;
                            LEG_STATE <= 1'b0;
                            LEG_VALID <= 1'b1;
                        end
                    end

                    ST_HIGH: begin
                        if (q_off) begin
                            state     <= ST_DEAD;
                            cnt       <= CNT_ONE;
                            prev_side <= SIDE_HIGH;
                            LEG_VALID <= 1'b0;
                        end else if (q_lo) begin
                            state     <= ST_LOW;
                            DT_LAST   <= '0;
                            DT_VALID  <= 1'b1;
                            LEG_STATE <= 1'b0;
                            LEG_VALID <= 1'b1;
                        end
                    end

                    ST_LOW: begin
                        if (q_off) begin
                            state     <= ST_DEAD;
                            cnt       <= CNT_ONE;
                            prev_side <= SIDE_LOW;
                            LEG_VALID <= 1'b0;
                        end else if (q_hi) begin
                            state     <= ST_HIGH;
                            DT_LAST   <= '0;
                            DT_VALID  <= 1'b1;
                            LEG_STATE <= 1'b1;
                            LEG_VALID <= 1'b1;
                        end
                    end

                    ST_DEAD: begin
                        if (q_off) begin
                            cnt <= cnt_inc;
                        end else if (q_hi) begin
                            state     <= ST_HIGH;
                            DT_LAST   <= cnt;
                            DT_VALID  <= 1'b1;
                            LEG_STATE <= 1'b1;
                            LEG_VALID <= 1'b1;
                        end else if (q_lo) begin
                            state     <= ST_LOW;
                            DT_LAST   <= cnt;
                            DT_VALID  <= 1'b1;
                            LEG_STATE <= 1'b0;
                            LEG_VALID <= 1'b1;
                        end
                    end

                    ST_SHOOT: begin
                        if (q_off) begin
                            state     <= ST_DEAD;
                            cnt       <= CNT_ONE;
                            prev_side <= SIDE_NONE;
                        end else if (q_hi) begin
                            state     <= ST_HIGH;
                            LEG_STATE <= 1'b1;
                            LEG_VALID <= 1'b1;
                        end else if (q_lo) begin
                            state     <= ST_LOW;
                            LEG_STATE <= 1'b0;
                            LEG_VALID <= 1'b1;
                        end
                    end

                    default: begin
                        state     <= ST_IDLE;
                        LEG_STATE <= 1'b0;
                        LEG_VALID <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_leg_gate_monitor.sv
// Directed bench for leg_gate_monitor: linear stimulus with hand-computed
// expectations, checked by immediate assertions.
module tb_leg_gate_monitor;

    logic       CLK;
    logic       RST_N;
    logic       Q1;
    logic       Q2;
    logic       FAULT_CLR;
    logic       LEG_STATE;
    logic       LEG_VALID;
    logic [7:0] DT_LAST;
    logic       DT_VALID;
    logic       FAULT_SHOOT;
    logic       FAULT_DT_SHORT;
    logic       FAULT_DT_LONG;
    logic       FAULT;

    int total = 0;
    int bad   = 0;
    int dtv_cnt = 0;
    int dtv_base;

    leg_gate_monitor #(
        .CNT_W       (8),
        .MIN_DEADTIME(5),
        .MAX_DEADTIME(64)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .Q1            (Q1),
        .Q2            (Q2),
        .FAULT_CLR     (FAULT_CLR),
        .LEG_STATE     (LEG_STATE),
        .LEG_VALID     (LEG_VALID),
        .DT_LAST       (DT_LAST),
        .DT_VALID      (DT_VALID),
        .FAULT_SHOOT   (FAULT_SHOOT),
        .FAULT_DT_SHORT(FAULT_DT_SHORT),
        .FAULT_DT_LONG (FAULT_DT_LONG),
        .FAULT         (FAULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count DT_VALID pulses, sampled mid-cycle.
    always @(negedge CLK) begin
        if (DT_VALID === 1'b1) dtv_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] q);
        Q1 = q[1];
        Q2 = q[0];
    endtask

    task automatic pulse_clear();
        FAULT_CLR = 1'b1;
        tick(1);
        FAULT_CLR = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0;
        FAULT_CLR = 1'b0;
        drive(2'b00);

        // Power-on reset, then release with 00 held: stays idle
        tick(2);
        chk("por_flags", {25'd0, LEG_STATE, LEG_VALID, DT_VALID, FAULT_SHOOT,
                          FAULT_DT_SHORT, FAULT_DT_LONG, FAULT}, 32'd0);
        RST_N = 1'b1;
        tick(4);
        chk("idle_valid", {31'd0, LEG_VALID}, 32'd0);
        chk("idle_no_dtv", dtv_cnt, 32'd0);

        // Nominal: 10 x10, 00 x5, then 01
        drive(2'b10);
        tick(10);
        chk("nom_high_state", {31'd0, LEG_STATE}, 32'd1);
        chk("nom_high_valid", {31'd0, LEG_VALID}, 32'd1);
        dtv_base = dtv_cnt;
        drive(2'b00);
        tick(2);
        chk("nom_dead_valid", {31'd0, LEG_VALID}, 32'd0);
        chk("nom_dead_hold", {31'd0, LEG_STATE}, 32'd1);
        tick(3);
        drive(2'b01);
        tick(2);
        chk("nom_dt_last", {24'd0, DT_LAST}, 32'd5);
        chk("nom_dt_valid", {31'd0, DT_VALID}, 32'd1);
        chk("nom_low_state", {31'd0, LEG_STATE}, 32'd0);
        chk("nom_low_valid", {31'd0, LEG_VALID}, 32'd1);
        chk("nom_fault", {31'd0, FAULT}, 32'd0);
        tick(1);
        chk("nom_dtv_once", dtv_cnt - dtv_base, 32'd1);
        chk("nom_dtv_drop", {31'd0, DT_VALID}, 32'd0);

        // Short dead time: 01, 00 x3, then 10
        drive(2'b00);
        tick(3);
        drive(2'b10);
        tick(2);
        chk("short_dt_last", {24'd0, DT_LAST}, 32'd3);
        chk("short_flag", {31'd0, FAULT_DT_SHORT}, 32'd1);
        chk("short_fault", {31'd0, FAULT}, 32'd1);
        tick(3);
        chk("short_sticky", {31'd0, FAULT_DT_SHORT}, 32'd1);
        pulse_clear();
        chk("short_cleared", {31'd0, FAULT_DT_SHORT}, 32'd0);
        chk("short_fault_clr", {31'd0, FAULT}, 32'd0);

        // Asynchronous reset mid-run with Q1=1 (leg is HIGH, DT_LAST=3)
        tick(2);
        RST_N = 1'b0;
        #1;
        chk("rst_flags", {25'd0, LEG_STATE, LEG_VALID, DT_VALID, FAULT_SHOOT,
                          FAULT_DT_SHORT, FAULT_DT_LONG, FAULT}, 32'd0);
        chk("rst_dt_last", {24'd0, DT_LAST}, 32'd0);
        drive(2'b00);
        tick(2);
        dtv_base = dtv_cnt;
        RST_N = 1'b1;
        tick(5);
        chk("rst_idle_valid", {31'd0, LEG_VALID}, 32'd0);
        chk("rst_idle_state", {31'd0, LEG_STATE}, 32'd0);
        chk("rst_no_dtv", dtv_cnt - dtv_base, 32'd0);

        // Shoot-through: 10, one 11, 00 x2, then 01
        drive(2'b10);
        tick(3);
        drive(2'b11);
        tick(1);
        drive(2'b00);
        tick(1);
        chk("shoot_flag", {31'd0, FAULT_SHOOT}, 32'd1);
        chk("shoot_valid", {31'd0, LEG_VALID}, 32'd0);
        chk("shoot_hold", {31'd0, LEG_STATE}, 32'd1);
        tick(1);
        drive(2'b01);
        tick(2);
        chk("shoot_no_short", {31'd0, FAULT_DT_SHORT}, 32'd0);
        chk("shoot_exit_low", {31'd0, LEG_STATE}, 32'd0);
        chk("shoot_sticky", {31'd0, FAULT_SHOOT}, 32'd1);
        pulse_clear();
        chk("shoot_cleared", {31'd0, FAULT}, 32'd0);

        // Return to the same side: measured, never short
        drive(2'b00);
        tick(2);
        drive(2'b01);
        tick(2);
        chk("same_dt_last", {24'd0, DT_LAST}, 32'd2);
        chk("same_no_short", {31'd0, FAULT_DT_SHORT}, 32'd0);

        // Legal change LOW -> HIGH with 6 cycles of dead time
        drive(2'b00);
        tick(6);
        drive(2'b10);
        tick(2);
        chk("legal_dt_last", {24'd0, DT_LAST}, 32'd6);
        chk("legal_fault", {31'd0, FAULT}, 32'd0);

        // Stalled dead time: 00 x70, then 01
        drive(2'b00);
        tick(64);
        chk("long_before", {31'd0, FAULT_DT_LONG}, 32'd0);
        tick(1);
        chk("long_set", {31'd0, FAULT_DT_LONG}, 32'd1);
        chk("long_fault", {31'd0, FAULT}, 32'd1);
        tick(5);
        drive(2'b01);
        tick(2);
        chk("long_dt_last", {24'd0, DT_LAST}, 32'd70);
        chk("long_dt_valid", {31'd0, DT_VALID}, 32'd1);
        chk("long_no_short", {31'd0, FAULT_DT_SHORT}, 32'd0);
        pulse_clear();
        chk("long_cleared", {31'd0, FAULT}, 32'd0);

        // Clear collides with shoot-through detection
        dtv_base = dtv_cnt;
        drive(2'b11);
        tick(1);
        FAULT_CLR = 1'b1;
        drive(2'b01);
        tick(1);
        FAULT_CLR = 1'b0;
        chk("coll_shoot_wins", {31'd0, FAULT_SHOOT}, 32'd1);
        tick(2);
        chk("coll_back_low", {30'd0, LEG_STATE, LEG_VALID}, 32'd1);
        chk("coll_no_dtv", dtv_cnt - dtv_base, 32'd0);
        pulse_clear();
        chk("coll_cleared", {31'd0, FAULT_SHOOT}, 32'd0);

        // Direct 10 -> 01 without dead time
        drive(2'b00);
        tick(7);
        drive(2'b10);
        tick(2);
        chk("pre_direct_dt", {24'd0, DT_LAST}, 32'd7);
        chk("pre_direct_fault", {31'd0, FAULT}, 32'd0);
        drive(2'b01);
        tick(2);
        chk("direct_dt_last", {24'd0, DT_LAST}, 32'd0);
        chk("direct_dt_valid", {31'd0, DT_VALID}, 32'd1);
        chk("direct_short", {31'd0, FAULT_DT_SHORT}, 32'd1);
        chk("direct_low", {31'd0, LEG_STATE}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
